// File: rtl/dbus_pkg.sv
// Shared types and constants for the core data-bus slave fabric.
package dbus_pkg;

  localparam int DATA_W = 19;
  localparam int ADDR_W = 19;

  // 256-word accelerator window; only addr[18:8] takes part in the match.
  localparam logic [ADDR_W-1:0] MMIO_BASE = 19'h7F000;

  // Load data returned when an MMIO access is abandoned.
  localparam logic [DATA_W-1:0] ERR_DATA = 19'h7FFFF;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    T_DMEM,
    T_MMIO,
    T_NONE
  } target_e;

endpackage

// File: rtl/dbus_dmem.sv
// Local data SRAM: single port, write-enable, registered read.
// Contents are deliberately not reset.
module dbus_dmem #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 19,
  parameter int AW    = 12
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write at the sampling edge; the read register only updates on a load,
  // so the last load result is held.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dbus_fabric.sv
// Data-bus slave: decodes requests to DMEM, the accelerator MMIO window or
// unmapped space, and stalls the pipeline while an MMIO access is open.
//
//   state | meaning
//   IDLE  | accepting requests; DMEM/unmapped complete here without stall
//   REQ   | MMIO request presented, waiting for acc_req_ready
//   RESP  | MMIO load accepted, waiting for acc_resp_valid
module dbus_fabric
  import dbus_pkg::*;
#(
  parameter int DMEM_DEPTH = 4096,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dbus_valid,
  input  logic              dbus_write,
  input  logic [ADDR_W-1:0] dbus_addr,
  input  logic [DATA_W-1:0] dbus_wdata,
  output logic [DATA_W-1:0] dbus_rdata,
  output logic              dbus_stall,
  output logic              bus_err,
  output logic              acc_req_valid,
  output logic              acc_req_write,
  output logic [7:0]        acc_addr,
  output logic [DATA_W-1:0] acc_wdata,
  input  logic              acc_req_ready,
  input  logic              acc_resp_valid,
  input  logic [DATA_W-1:0] acc_rdata
);

  localparam int                DMEM_AW    = $clog2(DMEM_DEPTH);
  localparam logic [ADDR_W-1:0] DMEM_LIMIT = ADDR_W'(DMEM_DEPTH);
  localparam int                CNT_W      = $clog2(TIMEOUT + 1);
  // The access is abandoned on the edge where the counter would reach
  // TIMEOUT, so the stall lasts at most TIMEOUT cycles.
  localparam logic [CNT_W-1:0]  TO_LAST    = CNT_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  target_e            tgt;
  logic               sample;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               stall_q, stall_d;
  logic               err_q, err_d;
  logic               req_valid_q, req_valid_d;
  logic               req_write_q, req_write_d;
  logic [7:0]         addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               sel_dmem_q, sel_dmem_d;
  logic               dmem_we, dmem_re;
  logic [DATA_W-1:0]  dmem_rdata;

  // Address decode; DMEM has priority over the MMIO window.
  always_comb begin
    tgt = T_NONE;
    if (dbus_addr < DMEM_LIMIT) begin
      tgt = T_DMEM;
    end else if (dbus_addr[ADDR_W-1:8] == MMIO_BASE[ADDR_W-1:8]) begin
      tgt = T_MMIO;
    end
  end

  assign sample  = !rst && (state_q == IDLE) && dbus_valid && !stall_q;
  assign dmem_we = sample && (tgt == T_DMEM) && dbus_write;
  assign dmem_re = sample && (tgt == T_DMEM) && !dbus_write;

  dbus_dmem #(
    .DEPTH (DMEM_DEPTH),
    .WIDTH (DATA_W),
    .AW    (DMEM_AW)
  ) u_dmem (
    .clk     (clk),
    .we_i    (dmem_we),
    .re_i    (dmem_re),
    .addr_i  (dbus_addr[DMEM_AW-1:0]),
    .wdata_i (dbus_wdata),
    .rdata_o (dmem_rdata)
  );

  // Next-state and output logic for the request/MMIO controller.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_d     = stall_q;
    err_d       = 1'b0;
    req_valid_d = req_valid_q;
    req_write_d = req_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    sel_dmem_d  = sel_dmem_q;

    unique case (state_q)
      IDLE: begin
        if (sample) begin
          unique case (tgt)
            T_DMEM: begin
              if (!dbus_write) begin
                sel_dmem_d = 1'b1;
              end
            end
            T_MMIO: begin
              state_d     = REQ;
              cnt_d       = '0;
              stall_d     = 1'b1;
              req_valid_d = 1'b1;
              req_write_d = dbus_write;
              addr_d      = dbus_addr[7:0];
              wdata_d     = dbus_wdata;
            end
            default: begin
              err_d = 1'b1;
              if (!dbus_write) begin
                rdata_d    = '0;
                sel_dmem_d = 1'b0;
              end
            end
          endcase
        end
      end

      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (acc_req_ready && req_write_q) begin
          state_d     = IDLE;
          stall_d     = 1'b0;
          req_valid_d = 1'b0;
        end else if (acc_req_ready && acc_resp_valid) begin
          // Response arriving with the acceptance completes the load at once.
          state_d     = IDLE;
          stall_d     = 1'b0;
          req_valid_d = 1'b0;
          rdata_d     = acc_rdata;
          sel_dmem_d  = 1'b0;
        end else if (cnt_q == TO_LAST) begin
          state_d     = IDLE;
          stall_d     = 1'b0;
          req_valid_d = 1'b0;
          err_d       = 1'b1;
          if (!req_write_q) begin
            rdata_d    = ERR_DATA;
            sel_dmem_d = 1'b0;
          end
        end else if (acc_req_ready) begin
          state_d     = RESP;
          req_valid_d = 1'b0;
        end
      end

      RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (acc_resp_valid) begin
          state_d    = IDLE;
          stall_d    = 1'b0;
          rdata_d    = acc_rdata;
          sel_dmem_d = 1'b0;
        end else if (cnt_q == TO_LAST) begin
          state_d    = IDLE;
          stall_d    = 1'b0;
          err_d      = 1'b1;
          rdata_d    = ERR_DATA;
          sel_dmem_d = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        stall_d     = 1'b0;
        req_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_q     <= 1'b0;
      err_q       <= 1'b0;
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      sel_dmem_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_q     <= stall_d;
      err_q       <= err_d;
      req_valid_q <= req_valid_d;
      req_write_q <= req_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      sel_dmem_q  <= sel_dmem_d;
    end
  end

  // DMEM loads are served straight from the RAM read register.
  assign dbus_rdata    = sel_dmem_q ? dmem_rdata : rdata_q;
  assign dbus_stall    = stall_q;
  assign bus_err       = err_q;
  assign acc_req_valid = req_valid_q;
  assign acc_req_write = req_write_q;
  assign acc_addr      = addr_q;
  assign acc_wdata     = wdata_q;

endmodule

// File: tb/tb_dbus_fabric.sv
// Bench for dbus_fabric: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_dbus_fabric;
  import dbus_pkg::*;

  localparam int TO = 255;

  logic              clk = 1'b0;
  logic              rst;
  logic              dbus_valid, dbus_write;
  logic [18:0]       dbus_addr, dbus_wdata, dbus_rdata;
  logic              dbus_stall, bus_err;
  logic              acc_req_valid, acc_req_write;
  logic [7:0]        acc_addr;
  logic [18:0]       acc_wdata, acc_rdata;
  logic              acc_req_ready, acc_resp_valid;

  always #5 clk = ~clk;

  dbus_fabric dut (
    .clk            (clk),
    .rst            (rst),
    .dbus_valid     (dbus_valid),
    .dbus_write     (dbus_write),
    .dbus_addr      (dbus_addr),
    .dbus_wdata     (dbus_wdata),
    .dbus_rdata     (dbus_rdata),
    .dbus_stall     (dbus_stall),
    .bus_err        (bus_err),
    .acc_req_valid  (acc_req_valid),
    .acc_req_write  (acc_req_write),
    .acc_addr       (acc_addr),
    .acc_wdata      (acc_wdata),
    .acc_req_ready  (acc_req_ready),
    .acc_resp_valid (acc_resp_valid),
    .acc_rdata      (acc_rdata)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [18:0] mem [4096];
  bit          memk [4096];
  logic [18:0] m_rdata, m_wdata;
  bit          m_rknown, m_stall, m_err, m_rv, m_rw;
  logic [7:0]  m_addr;
  bit          m_busy, m_accepted;
  int          m_age;
  bit          cmp_en = 0;

  initial for (int i = 0; i < 4096; i++) memk[i] = 0;

  always @(posedge clk) begin
    bit done;
    m_err = 0;
    if (rst) begin
      m_rdata = 0; m_rknown = 1; m_stall = 0; m_rv = 0; m_rw = 0;
      m_addr = 0; m_wdata = 0; m_busy = 0; m_accepted = 0; m_age = 0;
    end else if (!m_busy) begin
      if (dbus_valid) begin
        if (int'(dbus_addr) < 4096) begin
          if (dbus_write) begin
            mem[int'(dbus_addr)] = dbus_wdata;
            memk[int'(dbus_addr)] = 1;
          end else begin
            m_rdata  = mem[int'(dbus_addr)];
            m_rknown = memk[int'(dbus_addr)];
          end
        end else if (int'(dbus_addr) >= 'h7F000 && int'(dbus_addr) <= 'h7F0FF) begin
          m_busy = 1; m_accepted = 0; m_age = 0;
          m_rv = 1; m_stall = 1; m_rw = dbus_write;
          m_addr = 8'(int'(dbus_addr) - 'h7F000);
          m_wdata = dbus_wdata;
        end else begin
          m_err = 1;
          if (!dbus_write) begin m_rdata = 0; m_rknown = 1; end
        end
      end
    end else begin
      done = 0;
      m_age++;
      if (!m_accepted && acc_req_ready) begin
        if (m_rw) done = 1;
        else if (acc_resp_valid) begin m_rdata = acc_rdata; m_rknown = 1; done = 1; end
        else begin m_accepted = 1; m_rv = 0; end
      end else if (m_accepted && acc_resp_valid) begin
        m_rdata = acc_rdata; m_rknown = 1; done = 1;
      end
      if (!done && m_age >= TO) begin
        m_err = 1; done = 1;
        if (!m_rw) begin m_rdata = 19'h7FFFF; m_rknown = 1; end
      end
      if (done) begin m_busy = 0; m_stall = 0; m_rv = 0; end
    end
    cmp_en = 1;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("stall", dbus_stall, m_stall);
      chk("bus_err", bus_err, m_err);
      chk("acc_req_valid", acc_req_valid, m_rv);
      chk("acc_req_write", acc_req_write, m_rw);
      chk("acc_addr", acc_addr, m_addr);
      chk("acc_wdata", acc_wdata, m_wdata);
      if (m_rknown) chk("rdata", dbus_rdata, m_rdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic w, input logic [18:0] a, input logic [18:0] d);
    dbus_valid = 1; dbus_write = w; dbus_addr = a; dbus_wdata = d;
  endtask

  task automatic idle();
    dbus_valid = 0; dbus_write = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rdata"}, dbus_rdata, 0);
    chk({tag, "_stall"}, dbus_stall, 0);
    chk({tag, "_err"}, bus_err, 0);
    chk({tag, "_reqv"}, acc_req_valid, 0);
    chk({tag, "_reqw"}, acc_req_write, 0);
    chk({tag, "_addr"}, acc_addr, 0);
    chk({tag, "_wdata"}, acc_wdata, 0);
  endtask

  function automatic logic [18:0] pick_addr();
    case ($urandom_range(0, 7))
      0, 1:    return 19'($urandom_range(0, 15));
      2:       return 19'($urandom_range(4080, 4095));
      3:       return 19'($urandom_range(4096, 4100));
      4, 5:    return 19'('h7F000 + $urandom_range(0, 255));
      6:       return ($urandom_range(0, 1) != 0) ? 19'h7EFFF : 19'h7F100;
      default: return 19'($urandom);
    endcase
  endfunction

  initial begin
    int n;
    rst = 1; dbus_valid = 0; dbus_write = 0; dbus_addr = 0; dbus_wdata = 0;
    acc_req_ready = 0; acc_resp_valid = 0; acc_rdata = 0;
    repeat (3) step();
    chk_zero("reset");
    rst = 0;
    step();

    // DMEM round trip
    drive(1, 19'h00010, 19'h12345);
    step();
    chk("dm_st_stall", dbus_stall, 0);
    drive(0, 19'h00010, 0);
    step();
    idle();
    chk("dm_ld_data", dbus_rdata, 19'h12345);
    chk("dm_ld_stall", dbus_stall, 0);

    // Unmapped load
    drive(0, 19'h20000, 0);
    step();
    idle();
    chk("um_ld_data", dbus_rdata, 0);
    chk("um_ld_err", bus_err, 1);
    chk("um_ld_stall", dbus_stall, 0);
    step();
    chk("um_ld_err_end", bus_err, 0);
    drive(0, 19'h00010, 0);
    step();
    chk("um_pre_data", dbus_rdata, 19'h12345);
    drive(1, 19'h20000, 19'h3ABCD);
    step();
    chk("um_st_err", bus_err, 1);
    drive(0, 19'h20000, 0);
    step();
    idle();
    chk("um_ld2_data", dbus_rdata, 0);
    chk("um_ld2_err", bus_err, 1);
    step();
    chk("um_ld2_err_end", bus_err, 0);

    // MMIO store, ready after 3 cycles
    drive(1, 19'h7F004, 19'h00ABC);
    acc_req_ready = 0;
    step();
    idle();
    for (int c = 0; c < 4; c++) begin
      chk("mst_addr", acc_addr, 8'h04);
      chk("mst_wdata", acc_wdata, 19'h00ABC);
      chk("mst_reqv", acc_req_valid, 1);
      chk("mst_stall", dbus_stall, 1);
      if (c == 3) acc_req_ready = 1;
      step();
    end
    acc_req_ready = 0;
    chk("mst_stall_end", dbus_stall, 0);
    chk("mst_reqv_end", acc_req_valid, 0);

    // MMIO load, ready after 1, response 2 cycles later
    drive(0, 19'h7F010, 0);
    step();
    idle();
    chk("mld_addr", acc_addr, 8'h10);
    chk("mld_stall", dbus_stall, 1);
    acc_req_ready = 1;
    step();
    acc_req_ready = 0;
    chk("mld_reqv_drop", acc_req_valid, 0);
    step();
    chk("mld_wait_stall", dbus_stall, 1);
    acc_resp_valid = 1; acc_rdata = 19'h55555;
    step();
    acc_resp_valid = 0;
    chk("mld_stall_end", dbus_stall, 0);
    chk("mld_data", dbus_rdata, 19'h55555);

    // MMIO timeout
    drive(0, 19'h7F020, 0);
    step();
    idle();
    n = 0;
    while (dbus_stall === 1'b1 && n < 400) begin
      n++;
      step();
    end
    chk("to_stall_cycles", n, TO);
    chk("to_stall", dbus_stall, 0);
    chk("to_err", bus_err, 1);
    chk("to_data", dbus_rdata, 19'h7FFFF);
    chk("to_reqv", acc_req_valid, 0);
    step();
    chk("to_err_end", bus_err, 0);
    drive(0, 19'h00010, 0);
    step();
    idle();
    chk("to_dm_data", dbus_rdata, 19'h12345);
    chk("to_dm_stall", dbus_stall, 0);

    // Reset while waiting for the response
    drive(0, 19'h7F030, 0);
    step();
    idle();
    acc_req_ready = 1;
    step();
    acc_req_ready = 0;
    chk("rm_stall", dbus_stall, 1);
    rst = 1;
    step();
    rst = 0;
    chk_zero("rm");
    acc_resp_valid = 1; acc_rdata = 19'h01234;
    step();
    acc_resp_valid = 0;
    chk("rm_late_data", dbus_rdata, 0);
    chk("rm_late_stall", dbus_stall, 0);

    // Randomized traffic; quiet windows starve the accelerator to hit timeouts
    for (int i = 0; i < 4000; i++) begin
      rst            = ($urandom_range(0, 399) == 0);
      dbus_valid     = ($urandom_range(0, 2) != 0);
      dbus_write     = 1'($urandom_range(0, 1));
      dbus_addr      = pick_addr();
      dbus_wdata     = 19'($urandom);
      acc_rdata      = 19'($urandom);
      if ((i % 1000) >= 600 && (i % 1000) < 900) begin
        acc_req_ready  = 0;
        acc_resp_valid = 0;
      end else begin
        acc_req_ready  = ($urandom_range(0, 3) == 0);
        acc_resp_valid = ($urandom_range(0, 3) == 0);
      end
      step();
    end
    rst = 0; idle(); acc_req_ready = 0; acc_resp_valid = 0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dbus_fabric.md
Name: dbus_fabric

Overview:
- Slave side of the 19-bit core data bus. It consumes the registered request from the memory stage and returns load data.
- Address-decodes each request to one of three targets:
  - the local data SRAM (DMEM);
  - the accelerator MMIO window (FFT/crypto register file), reached through a valid/ready handshake;
  - unmapped space.
- Back-pressures the pipeline with dbus_stall while an MMIO access is outstanding.

Parameters:
- DATA_W, 19, bus data width
- ADDR_W, 19, bus word-address width
- DMEM_DEPTH, 4096, DMEM words; addresses 0..DMEM_DEPTH-1 map to DMEM
- MMIO_BASE, 19'h7F000, base of a 256-word MMIO window; match on addr[18:8]
- TIMEOUT, 255, maximum cycles an MMIO access may stay outstanding

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  synchronous, active-high reset
- dbus_valid  in  1  request present this cycle
- dbus_write  in  1  1 = store, 0 = load
- dbus_addr  in  ADDR_W  word address
- dbus_wdata  in  DATA_W  store data
- dbus_rdata  out  DATA_W  load data
- dbus_stall  out  1  upstream must hold its request and pipeline while high
- bus_err  out  1  one-cycle pulse on unmapped access or MMIO timeout
- acc_req_valid  out  1  MMIO request to accelerators
- acc_req_write  out  1  MMIO store flag
- acc_addr  out  8  MMIO word offset (dbus_addr[7:0])
- acc_wdata  out  DATA_W  MMIO store data
- acc_req_ready  in  1  accelerator accepts the request
- acc_resp_valid  in  1  MMIO read data valid (loads only)
- acc_rdata  in  DATA_W  MMIO read data

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Reset values:
  - dbus_rdata=0, dbus_stall=0, bus_err=0, acc_req_valid=0, acc_req_write=0, acc_addr=0, acc_wdata=0.
  - FSM=IDLE, timeout counter=0.
  - DMEM contents are not reset.
- Requests are sampled only in IDLE. dbus_valid is ignored while dbus_stall=1.
- Decode priority: DMEM (addr < DMEM_DEPTH), then MMIO (addr[18:8]==MMIO_BASE[18:8]), then unmapped.
- DMEM store: written at the sampling edge. No stall.
- DMEM load: synchronous read. dbus_rdata is valid in the cycle after the sampling edge and held until the next completed load.
- Store then load to the same address on consecutive cycles: the load returns the new data (the RAM is read-after-write coherent across cycles).
- Unmapped access:
  - Store is dropped. Load sets dbus_rdata=0.
  - bus_err pulses for 1 cycle, in the cycle after sampling. No stall.
- MMIO FSM:
  - IDLE: on an MMIO request, register acc_addr, acc_wdata and acc_req_write, and set acc_req_valid=1 and dbus_stall=1. Go to REQ.
  - REQ: hold acc_req_valid and all acc_* outputs stable until acc_req_ready=1.
    - On the accepting edge, drop acc_req_valid.
    - A store goes to IDLE with dbus_stall=0 on the next cycle.
    - A load goes to RESP.
  - RESP: wait for acc_resp_valid=1. On that edge, dbus_rdata<=acc_rdata, dbus_stall<=0, go to IDLE.
  - acc_resp_valid arriving in the same cycle as acc_req_ready for a load is captured; go directly to IDLE.
  - acc_resp_valid while in IDLE or REQ is ignored.
- Timeout:
  - The counter clears on entry to REQ and increments each cycle in REQ or RESP.
  - When the counter reaches TIMEOUT: go to IDLE, drop acc_req_valid, set dbus_rdata=19'h7FFFF for a load, pulse bus_err, drop dbus_stall.
- Latency:
  - DMEM: 1 cycle, no stall.
  - MMIO store: 1 + ready wait cycles.
  - MMIO load: 1 + ready wait + response wait cycles.
- Reset mid-access: the FSM returns to IDLE and all outputs go to their reset values. A late acc_resp_valid is ignored.

Decomposition:
- Shared package dbus_pkg:
  - DATA_W, ADDR_W, MMIO_BASE;
  - FSM state enum {IDLE, REQ, RESP};
  - target enum {T_DMEM, T_MMIO, T_NONE};
  - ERR_DATA=19'h7FFFF.
- One sub-module, dbus_dmem: a single-port synchronous-read RAM (DMEM_DEPTH x DATA_W, write enable, registered read).
- Decode and the MMIO FSM stay in dbus_fabric.

Test Plan:
- DMEM round trip: store 19'h12345 @0x010, then load @0x010. Required: dbus_rdata=19'h12345 one cycle after the load is sampled; dbus_stall never asserts.
- Unmapped access: load @0x20000. Required: dbus_rdata=0, bus_err high for exactly 1 cycle, no stall. Then store @0x20000 followed by load @0x20000: the store is dropped, so the load also returns 0 with a 1-cycle bus_err pulse.
- MMIO store with ready delayed 3 cycles, wdata=19'h00ABC @0x7F004. Required:
  - acc_addr=8'h04 and acc_wdata stable for 4 cycles;
  - dbus_stall deasserts 1 cycle after the acceptance.
- MMIO load @0x7F010: ready after 1 cycle, acc_resp_valid 2 cycles later with acc_rdata=19'h55555. Required: dbus_rdata=19'h55555 when dbus_stall falls.
- MMIO timeout: acc_req_ready held 0. Required:
  - after TIMEOUT cycles, bus_err pulses, dbus_rdata=19'h7FFFF and dbus_stall=0;
  - a subsequent DMEM load completes normally.
- Reset mid-access: assert rst while in RESP. Required: next cycle all outputs are 0 and the FSM is IDLE; a stray acc_resp_valid afterwards does not change dbus_rdata.
